// File: rtl/audio_pkg.sv
// audio_pkg: constants and types shared by the audio record/playback blocks.
//   AUDIO_SAMPLE_BITS : default captured bits per channel
//   AUDIO_FIFO_DEPTH  : default number of buffered stereo frames
//   stereo_frame_t    : packed {left, right} sample pair
package audio_pkg;

    localparam int unsigned AUDIO_SAMPLE_BITS = 16;
    localparam int unsigned AUDIO_FIFO_DEPTH  = 8;

    typedef struct packed {
        logic [AUDIO_SAMPLE_BITS-1:0] left;
        logic [AUDIO_SAMPLE_BITS-1:0] right;
    } stereo_frame_t;

endpackage

// File: rtl/stereo_frame_fifo.sv
// stereo_frame_fifo: synchronous show-ahead FIFO of stereo frames (not fall-through:
// a frame written into an empty FIFO becomes visible the following cycle).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (ignored when full unless popping in the same cycle)
//   i_data     : frame to write
//   i_pop      : remove head (ignored when empty)
//   o_head     : current head frame
//   o_full     : DEPTH frames stored
//   o_empty    : no frames stored
module stereo_frame_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = AUDIO_FIFO_DEPTH,
    parameter type FRAME_T = stereo_frame_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_push,
    input  FRAME_T i_data,
    input  logic   i_pop,
    output FRAME_T o_head,
    output logic   o_full,
    output logic   o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    FRAME_T             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture: I2S record-path receiver. Oversamples bclk/reclrc/recdat in the mclk
// domain, deserialises MSB-first words, pairs left/right into stereo frames and queues
// them in a show-ahead FIFO with a valid/ready output.
// Ports:
//   mclk, rstn          : sole clock, asynchronous active-low reset
//   enable              : capture enable; low drops lock and blocks new frames
//   i2s_bclk/reclrc/recdat : codec pins (asynchronous)
//   m_valid/m_ready     : frame handshake; m_left/m_right carry the head frame
//   locked              : word-clock edge seen since reset/enable
//   overflow            : sticky, frame dropped on full FIFO
//   short_err_cnt       : saturating count of truncated words
//   clear_flags         : pulse clearing overflow and short_err_cnt (wins over new events)
module i2s_rx_capture
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS  = AUDIO_SAMPLE_BITS,
    parameter int unsigned FIFO_DEPTH   = AUDIO_FIFO_DEPTH,
    parameter int unsigned ERR_CNT_BITS = 8
) (
    input  logic                    mclk,
    input  logic                    rstn,
    input  logic                    enable,
    input  logic                    i2s_bclk,
    input  logic                    i2s_reclrc,
    input  logic                    i2s_recdat,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [SAMPLE_BITS-1:0]  m_left,
    output logic [SAMPLE_BITS-1:0]  m_right,
    output logic                    locked,
    output logic                    overflow,
    output logic [ERR_CNT_BITS-1:0] short_err_cnt,
    input  logic                    clear_flags
);

    typedef struct packed {
        logic [SAMPLE_BITS-1:0] left;
        logic [SAMPLE_BITS-1:0] right;
    } rx_frame_t;

    localparam int unsigned POS_W = $clog2(SAMPLE_BITS + 2);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(SAMPLE_BITS);
    localparam logic [POS_W-1:0] POS_SAT  = POS_W'(SAMPLE_BITS + 1);
    localparam logic [ERR_CNT_BITS-1:0] ERR_MAX = '1;

    // Synchronisers
    logic r_bclk_s1, r_bclk_s2, r_bclk_prev;
    logic r_lr_s1, r_lr_s2;
    logic r_dat_s1, r_dat_s2;

    // Deserialiser state
    logic                   r_lr_prev;
    logic                   r_lr_seen;   // r_lr_prev holds a real sample
    logic                   r_locked;
    logic                   r_chan;
    logic [POS_W-1:0]       r_pos;
    logic [SAMPLE_BITS-1:0] r_shift;
    logic [SAMPLE_BITS-1:0] r_left_hold;
    logic                   r_left_ok;
    logic                   r_push;
    rx_frame_t              r_push_frame;

    // Flags
    logic                    r_overflow;
    logic [ERR_CNT_BITS-1:0] r_err_cnt;

    logic                   w_bclk_rise;
    logic                   w_boundary;
    logic [POS_W-1:0]       w_pos_inc;
    logic [SAMPLE_BITS-1:0] w_shift_next;
    logic                   w_word_done;
    logic                   w_short;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_fifo_pop;
    logic                   w_drop;
    rx_frame_t              w_head;

    assign w_bclk_rise  = r_bclk_s2 & ~r_bclk_prev;
    // The first rising edge after reset/enable only seeds r_lr_prev, so a lock needs a
    // genuine reclrc transition rather than a comparison against the reset value.
    assign w_boundary   = w_bclk_rise & r_lr_seen & (r_lr_s2 != r_lr_prev);
    assign w_pos_inc    = (r_pos == POS_SAT) ? r_pos : r_pos + POS_W'(1);
    assign w_shift_next = {r_shift[SAMPLE_BITS-2:0], r_dat_s2};
    // pos saturates above POS_LAST, so reaching POS_LAST happens once per word.
    assign w_word_done  = w_bclk_rise & ~w_boundary & r_locked & (w_pos_inc == POS_LAST);
    assign w_short      = w_boundary & r_locked & (r_pos < POS_LAST);

    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            r_bclk_s1   <= 1'b0;
            r_bclk_s2   <= 1'b0;
            r_bclk_prev <= 1'b0;
            r_lr_s1     <= 1'b0;
            r_lr_s2     <= 1'b0;
            r_dat_s1    <= 1'b0;
            r_dat_s2    <= 1'b0;
        end else begin
            r_bclk_s1   <= i2s_bclk;
            r_bclk_s2   <= r_bclk_s1;
            r_bclk_prev <= r_bclk_s2;
            r_lr_s1     <= i2s_reclrc;
            r_lr_s2     <= r_lr_s1;
            r_dat_s1    <= i2s_recdat;
            r_dat_s2    <= r_dat_s1;
        end
    end

    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            r_lr_prev    <= 1'b0;
            r_lr_seen    <= 1'b0;
            r_locked     <= 1'b0;
            r_chan       <= 1'b0;
            r_pos        <= '0;
            r_shift      <= '0;
            r_left_hold  <= '0;
            r_left_ok    <= 1'b0;
            r_push       <= 1'b0;
            r_push_frame <= '0;
        end else begin
            r_push <= 1'b0;
            if (w_bclk_rise) begin
                r_lr_prev <= r_lr_s2;
            end
            if (!enable) begin
                r_lr_seen <= 1'b0;
                r_locked  <= 1'b0;
                r_pos     <= '0;
                r_left_ok <= 1'b0;
            end else if (w_bclk_rise) begin
                r_lr_seen <= 1'b1;
                if (w_boundary) begin
                    // This bit is the previous word's trailing bit (I2S one-bit delay).
                    r_pos    <= '0;
                    r_chan   <= r_lr_s2;
                    r_locked <= 1'b1;
                    if (w_short) begin
                        r_left_ok <= 1'b0;
                    end
                end else begin
                    r_pos <= w_pos_inc;
                    if (w_pos_inc <= POS_LAST) begin
                        r_shift <= w_shift_next;
                    end
                    if (w_word_done) begin
                        if (!r_chan) begin
                            r_left_hold <= w_shift_next;
                            r_left_ok   <= 1'b1;
                        end else if (r_left_ok) begin
                            r_push       <= 1'b1;
                            r_push_frame <= '{left: r_left_hold, right: w_shift_next};
                            r_left_ok    <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign w_fifo_pop = ~w_fifo_empty & m_ready;
    assign w_drop     = r_push & w_fifo_full & ~w_fifo_pop;

    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
            r_err_cnt  <= '0;
        end else if (clear_flags) begin
            r_overflow <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_short && (r_err_cnt != ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_BITS'(1);
            end
        end
    end

    stereo_frame_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .FRAME_T (rx_frame_t)
    ) u_fifo (
        .clk     (mclk),
        .rst_n   (rstn),
        .i_push  (r_push),
        .i_data  (r_push_frame),
        .i_pop   (w_fifo_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign m_valid       = ~w_fifo_empty;
    assign m_left        = w_head.left;
    assign m_right       = w_head.right;
    assign locked        = r_locked;
    assign overflow      = r_overflow;
    assign short_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// tb_i2s_rx_capture: randomized + directed bench for i2s_rx_capture. Stimulus is
// described as I2S slots (channel, length, word); a slot-level model predicts frames,
// drops and short-word errors.
module tb_i2s_rx_capture;

    localparam int unsigned SB    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned EB    = 8;

    logic          mclk = 1'b0;
    logic          rstn = 1'b0;
    logic          enable = 1'b0;
    logic          i2s_bclk = 1'b0;
    logic          i2s_reclrc = 1'b0;
    logic          i2s_recdat = 1'b0;
    logic          m_ready = 1'b0;
    logic          clear_flags = 1'b0;
    logic          m_valid;
    logic [SB-1:0] m_left;
    logic [SB-1:0] m_right;
    logic          locked;
    logic          overflow;
    logic [EB-1:0] short_err_cnt;

    i2s_rx_capture #(
        .SAMPLE_BITS  (SB),
        .FIFO_DEPTH   (DEPTH),
        .ERR_CNT_BITS (EB)
    ) dut (
        .mclk          (mclk),
        .rstn          (rstn),
        .enable        (enable),
        .i2s_bclk      (i2s_bclk),
        .i2s_reclrc    (i2s_reclrc),
        .i2s_recdat    (i2s_recdat),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_left        (m_left),
        .m_right       (m_right),
        .locked        (locked),
        .overflow      (overflow),
        .short_err_cnt (short_err_cnt),
        .clear_flags   (clear_flags)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- slot-level reference model ----------------
    logic [31:0] exp_q[$];
    bit          m_en       = 1'b1;
    bit          m_seeded   = 1'b0;
    bit          m_locked   = 1'b0;
    bit          prev_short = 1'b0;
    bit          left_ok    = 1'b0;
    logic [15:0] left_hold  = '0;
    int          exp_err    = 0;
    bit          exp_ov     = 1'b0;

    task automatic model_reset();
        exp_q.delete();
        m_seeded   = 1'b0;
        m_locked   = 1'b0;
        prev_short = 1'b0;
        left_ok    = 1'b0;
        exp_err    = 0;
        exp_ov     = 1'b0;
    endtask

    // A slot carries its word in bits 1..len-1 (bit 0 is the previous word's tail).
    task automatic model_slot(input bit ch, input int len, input logic [15:0] word);
        if (!m_en) return;
        if (m_locked && prev_short) begin
            if (exp_err < 255) exp_err++;
            left_ok = 1'b0;
        end
        if (!m_seeded) begin
            m_seeded   = 1'b1;
            prev_short = 1'b0;
            return;
        end
        m_locked   = 1'b1;
        prev_short = (len - 1 < int'(SB));
        if (!prev_short) begin
            if (!ch) begin
                left_hold = word;
                left_ok   = 1'b1;
            end else if (left_ok) begin
                left_ok = 1'b0;
                if (exp_q.size() >= DEPTH) exp_ov = 1'b1;
                else exp_q.push_back({left_hold, word});
            end
        end
    endtask

    // ---------------- pin driver ----------------
    int rlsb_cyc = 0;

    task automatic send_bit(input bit lr, input bit dat, output int rc);
        @(negedge mclk);
        i2s_bclk   = 1'b0;
        i2s_reclrc = lr;
        i2s_recdat = dat;
        @(negedge mclk);
        @(negedge mclk);
        i2s_bclk = 1'b1;
        rc = cyc;
        @(negedge mclk);
    endtask

    task automatic send_slot(input bit ch, input int len, input logic [15:0] word,
                             input bit fill_ones);
        int  rc;
        bit  dat;
        model_slot(ch, len, word);
        for (int i = 0; i < len; i++) begin
            if (i >= 1 && i <= int'(SB)) dat = word[int'(SB) - i];
            else dat = fill_ones ? 1'b1 : 1'($urandom_range(0, 1));
            send_bit(ch, dat, rc);
            if (ch && i == int'(SB)) rlsb_cyc = rc;
        end
    endtask

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, 32, l, 1'b0);
        send_slot(1'b1, 32, r, 1'b0);
    endtask

    // ---------------- consumer ----------------
    int ready_mode = 0;  // 0 hold low, 1 hold high, 2 random

    initial forever begin
        @(posedge mclk);
        #1;
        if (ready_mode == 2) m_ready = 1'($urandom_range(0, 1));
        else m_ready = (ready_mode == 1);
    end

    bit prev_v = 1'b0;
    int vrise_cyc = 0;

    initial forever begin
        @(negedge mclk);
        if (m_valid && !prev_v) vrise_cyc = cyc;
        prev_v = m_valid;
        if (rstn && m_valid && m_ready) begin
            if (exp_q.size() == 0) check_val("pop_with_no_expected_frame", 64'(exp_q.size()), 1);
            else check_val("frame", {m_left, m_right}, exp_q.pop_front());
        end
    end

    task automatic drain(input string tag);
        int n;
        ready_mode = 1;
        n = 0;
        while (n < 400 && (exp_q.size() != 0 || m_valid)) begin
            @(negedge mclk);
            n++;
        end
        check_val({tag, "_drained"}, 64'(exp_q.size()), 0);
        ready_mode = 0;
        repeat (3) @(negedge mclk);
        check_val({tag, "_valid_low"}, m_valid, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rc;
        enable = 1'b1;
        // Reset with pins toggling
        for (int i = 0; i < 20; i++) begin
            @(negedge mclk);
            i2s_bclk   = 1'($urandom_range(0, 1));
            i2s_reclrc = 1'($urandom_range(0, 1));
            i2s_recdat = 1'($urandom_range(0, 1));
        end
        check_val("rst_valid", m_valid, 0);
        check_val("rst_left", m_left, 0);
        check_val("rst_right", m_right, 0);
        check_val("rst_locked", locked, 0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_errcnt", short_err_cnt, 0);
        @(negedge mclk);
        i2s_bclk = 1'b0; i2s_reclrc = 1'b0; i2s_recdat = 1'b0;
        @(negedge mclk);
        rstn = 1'b1;

        // Seed slot without a word-clock edge: no lock yet
        send_slot(1'b0, 4, 16'h0, 1'b0);
        check_val("no_lock_before_edge", locked, 0);
        check_val("no_frame_before_lock", m_valid, 0);

        // Basic frame and latency
        send_slot(1'b1, 32, 16'h5A5A, 1'b0);
        check_val("locked_after_edge", locked, 1);
        send_pair(16'h1234, 16'hABCD);
        check_val("basic_valid", m_valid, 1);
        check_val("basic_left", m_left, 16'h1234);
        check_val("basic_right", m_right, 16'hABCD);
        check_val("pin_to_valid_latency", 64'(vrise_cyc - rlsb_cyc), 4);
        drain("basic");

        // 24-bit slots with ones in the extra bits
        send_slot(1'b0, 24, 16'h8000, 1'b1);
        send_slot(1'b1, 24, 16'h7FFF, 1'b1);
        repeat (6) @(negedge mclk);
        check_val("slot24_left", m_left, 16'h8000);
        check_val("slot24_right", m_right, 16'h7FFF);
        check_val("slot24_errcnt", short_err_cnt, 0);
        drain("slot24");

        // Overflow: nine frames with the consumer stalled
        for (int i = 1; i <= 9; i++) send_pair(16'(i), 16'(i + 256));
        check_val("ovf_flag", overflow, exp_ov);
        check_val("ovf_head_left", m_left, 16'd1);
        drain("ovf");
        @(negedge mclk); clear_flags = 1'b1;
        @(negedge mclk); clear_flags = 1'b0;
        exp_ov = 1'b0; exp_err = 0;
        check_val("ovf_cleared", overflow, 0);

        // Short left word (10 data bits)
        send_slot(1'b0, 11, 16'($urandom), 1'b0);
        send_slot(1'b1, 32, 16'($urandom), 1'b0);
        send_pair(16'($urandom), 16'($urandom));
        check_val("short_errcnt", short_err_cnt, 64'(exp_err));
        drain("short");

        // Reset mid-right word with frames queued
        for (int i = 0; i < 3; i++) send_pair(16'($urandom), 16'($urandom));
        send_slot(1'b0, 32, 16'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'($urandom_range(0, 1)), rc);
        rstn = 1'b0;
        model_reset();
        repeat (2) @(negedge mclk);
        check_val("midrst_valid", m_valid, 0);
        check_val("midrst_locked", locked, 0);
        check_val("midrst_errcnt", short_err_cnt, 0);
        rstn = 1'b1;
        send_slot(1'b1, 20, 16'h0, 1'b0);
        send_pair(16'hC0DE, 16'h4321);
        check_val("midrst_left", m_left, 16'hC0DE);
        check_val("midrst_right", m_right, 16'h4321);
        drain("midrst");

        // Enable low drops lock; capture resumes after a fresh edge
        @(negedge mclk); enable = 1'b0;
        m_en = 1'b0; m_seeded = 1'b0; m_locked = 1'b0; left_ok = 1'b0; prev_short = 1'b0;
        repeat (4) @(negedge mclk);
        check_val("disable_locked", locked, 0);
        send_slot(1'b0, 32, 16'($urandom), 1'b0);
        check_val("disable_no_frame", m_valid, 0);
        enable = 1'b1; m_en = 1'b1;
        send_slot(1'b1, 32, 16'($urandom), 1'b0);
        send_pair(16'($urandom), 16'($urandom));
        drain("reenable");

        // Randomized slots with a random consumer
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            int len;
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 16))
                                              : int'($urandom_range(17, 32));
            send_slot(1'(i % 2), len, 16'($urandom), 1'b0);
        end
        drain("random");
        check_val("random_errcnt", short_err_cnt, 64'(exp_err));
        check_val("random_overflow", overflow, exp_ov);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_rx_capture.md
# i2s_rx_capture

I2S record-path receiver for the codec's ADC output, complementing the playback transmitter. Oversamples the codec-side bclk, reclrc and recdat pins in the mclk domain, deserialises MSB-first I2S words and pairs left/right into stereo frames. Frames land in a small FIFO with a valid/ready output, for a record/loopback consumer such as the audio combinator or a BRAM writer. Sticky overflow and short-word counters are exposed for the PS via GPIO.

## Interface
Parameters:
- SAMPLE_BITS, 16, captured bits per channel (MSB-first); extra slot bits ignored
- FIFO_DEPTH, 8, stereo frames buffered; power of two, ≥ 2
- ERR_CNT_BITS, 8, width of short-word counter (saturating)

Ports (one clock; reset asynchronous, active-low):
- mclk  in  1  codec master clock, sole clock of the block
- rstn  in  1  asynchronous active-low reset
- enable  in  1  capture enable; low forces unlocked, no pushes
- i2s_bclk  in  1  bit clock pin (asynchronous to mclk logic)
- i2s_reclrc  in  1  record word clock; 0 = left, 1 = right
- i2s_recdat  in  1  record serial data
- m_valid  out  1  head frame available
- m_ready  in  1  consumer accepts head frame
- m_left  out  SAMPLE_BITS  head left sample, two's complement
- m_right  out  SAMPLE_BITS  head right sample
- locked  out  1  a word-clock edge has been seen since reset/enable
- overflow  out  1  sticky: frame dropped on full FIFO
- short_err_cnt  out  ERR_CNT_BITS  saturating count of truncated words
- clear_flags  in  1  one-cycle pulse clears overflow and short_err_cnt

## Operation
- bclk, reclrc and recdat each pass through an identical 2-flop synchroniser; bclk rising edge = sync2 high and previous sync2 low. Requirement: bclk high and low phases ≥ 2 mclk cycles each (design point bclk = mclk/4).
- On each bclk rising edge: sample lr and dat. If lr differs from the lr at the previous rising edge: word boundary, pos ← 0, channel ← lr, locked ← 1. The bit at pos 0 belongs to the previous word and is discarded (I2S one-bit delay).
- pos 1..SAMPLE_BITS: shift dat into shift register, MSB first; pos increments, saturating at SAMPLE_BITS+1.
- When pos reaches SAMPLE_BITS: word complete. Left completion latches left_hold and sets left_ok. Right completion with left_ok pushes {left_hold, right} into the FIFO and clears left_ok. Right completion without left_ok is discarded silently.
- At a word boundary while locked, if the previous word had pos < SAMPLE_BITS: short_err_cnt += 1 (saturating), left_ok ← 0.
- Before locked, no completions count and no errors count.
- enable low: locked, pos, left_ok cleared and held; FIFO keeps draining; flags retained.
- FIFO: non-fall-through, show-ahead. Pop on m_valid && m_ready.
  - Push when full without a pop: frame dropped, overflow ← 1.
  - Push and pop together when full: both occur, no overflow.
  - Push into empty: m_valid rises the following cycle.
- clear_flags coincident with a new overflow or error event: the clear wins.
- Reset values: m_valid 0, m_left/m_right 0, locked 0, overflow 0, short_err_cnt 0, FIFO empty, all synchroniser and shift state 0.

## Timing
- Pin sample edge N (first mclk edge capturing bclk high): sync2 valid after N+1. Edge detect plus shift/latch at N+2. FIFO write at N+3. m_valid high after edge N+3, i.e. 4 mclk cycles pin-to-valid for the LSB of the right word.
- Pop is single-cycle: the next head (or m_valid 0) appears the cycle after a pop.
- rstn asserted mid-word: everything returns to reset values immediately (async). Capture restarts only after the next reclrc edge following deassertion.

## Structure
- Shared package audio_pkg: SAMPLE_BITS default constant, stereo_frame_t packed struct {left, right} of SAMPLE_BITS each, FIFO_DEPTH default.
- One sub-module: stereo_frame_fifo (parameterised depth, stereo_frame_t entries, full/empty, show-ahead). Synchroniser, edge detect and deserialiser stay in i2s_rx_capture.

## Test plan
- Reset: rstn low with pins toggling → all outputs 0, m_valid 0, locked 0; unchanged until the first reclrc edge after release.
- bclk = mclk/4, 32-bit slots, left 16'h1234 and right 16'hABCD → one frame m_left=16'h1234, m_right=16'hABCD; m_valid exactly 4 mclk after the right LSB bclk rise.
- 24-bit slots, left 16'h8000 plus 8 extra bits 0xFF, right 16'h7FFF → 16'h8000 / 16'h7FFF; extra bits ignored; short_err_cnt 0.
- m_ready=0, 9 frames (values 1..9) → frames 1..8 held, 9th dropped, overflow=1. Then m_ready=1 → pops 1..8 in order; clear_flags → overflow 0.
- reclrc toggles after 10 bits of a left word → short_err_cnt=1, no frame pushed for that pair; the following complete pair is pushed normally.
- rstn pulsed mid-right word with 3 frames queued → FIFO empty, locked 0; the next complete L/R pair after the first reclrc edge is captured correctly.
